// File: rtl/harvard_alu.sv
// Execute unit of the Harvard CPU: decodes one opcode per cycle and registers the new
// accumulator, store word, flags, program counter and the selected display word.
module harvard_alu #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clkInput,
  input  logic                  resetInput,
  input  logic [4:0]            OperandInput,
  input  logic [2:0]            OutputSelectorInput,
  input  logic [DATA_WIDTH-1:0] AccumulatorReadInput,
  input  logic [DATA_WIDTH-1:0] DataReadInput,
  input  logic                  ConditionFlagReadInput,
  output logic [DATA_WIDTH-1:0] AccumulatorWriteOutput,
  output logic [DATA_WIDTH-1:0] DataWriteOutput,
  output logic [DATA_WIDTH-1:0] OutputBinaryOutput,
  output logic [PC_WIDTH-1:0]   ProgramCounterOutput,
  output logic                  ConditionFlagWriteOutput,
  output logic                  EndFlagWriteOutput
);

  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_NOT   = 5'b00110;
  localparam logic [4:0] OP_SHL   = 5'b00111;
  localparam logic [4:0] OP_SHR   = 5'b01000;
  localparam logic [4:0] OP_INC   = 5'b01001;
  localparam logic [4:0] OP_DEC   = 5'b01010;
  localparam logic [4:0] OP_CMPEQ = 5'b01011;
  localparam logic [4:0] OP_CMPLT = 5'b01100;
  localparam logic [4:0] OP_ADD   = 5'b10000;
  localparam logic [4:0] OP_SUB   = 5'b10001;
  localparam logic [4:0] OP_JMP   = 5'b10010;
  localparam logic [4:0] OP_JF    = 5'b10011;
  localparam logic [4:0] OP_HALT  = 5'b10100;

  logic [DATA_WIDTH:0]   sumWide;
  logic [DATA_WIDTH:0]   diffWide;
  logic [DATA_WIDTH-1:0] resultNext;
  logic [DATA_WIDTH-1:0] dataNext;
  logic [DATA_WIDTH-1:0] outNext;
  logic [PC_WIDTH-1:0]   pcNext;
  logic                  flagNext;
  logic                  endNext;

  // Top bit of the widened sum is the carry; of the widened difference, the borrow.
  assign sumWide  = {1'b0, AccumulatorReadInput} + {1'b0, DataReadInput};
  assign diffWide = {1'b0, AccumulatorReadInput} - {1'b0, DataReadInput};

  always_comb begin
    resultNext = AccumulatorReadInput;
    dataNext   = DataWriteOutput;
    flagNext   = ConditionFlagReadInput;
    pcNext     = ProgramCounterOutput + PC_WIDTH'(1);
    endNext    = 1'b0;
    unique case (OperandInput)
      OP_LOAD:  resultNext = DataReadInput;
      OP_STORE: dataNext   = AccumulatorReadInput;
      OP_AND:   resultNext = AccumulatorReadInput & DataReadInput;
      OP_OR:    resultNext = AccumulatorReadInput | DataReadInput;
      OP_XOR:   resultNext = AccumulatorReadInput ^ DataReadInput;
      OP_NOT:   resultNext = ~AccumulatorReadInput;
      OP_SHL:   resultNext = AccumulatorReadInput << 1;
      OP_SHR:   resultNext = AccumulatorReadInput >> 1;
      OP_INC:   resultNext = AccumulatorReadInput + DATA_WIDTH'(1);
      OP_DEC:   resultNext = AccumulatorReadInput - DATA_WIDTH'(1);
      OP_CMPEQ: flagNext   = (AccumulatorReadInput == DataReadInput);
      OP_CMPLT: flagNext   = (AccumulatorReadInput < DataReadInput);
      OP_ADD: begin
        resultNext = sumWide[DATA_WIDTH-1:0];
        flagNext   = sumWide[DATA_WIDTH];
      end
      OP_SUB: begin
        resultNext = diffWide[DATA_WIDTH-1:0];
        flagNext   = diffWide[DATA_WIDTH];
      end
      OP_JMP:   pcNext = DataReadInput[PC_WIDTH-1:0];
      OP_JF:    if (ConditionFlagReadInput) pcNext = DataReadInput[PC_WIDTH-1:0];
      OP_HALT:  endNext = 1'b1;
      default:  ;
    endcase
  end

  // Display mux sees the values being registered this cycle, not the old ones.
  always_comb begin
    outNext = OutputBinaryOutput;
    unique case (OutputSelectorInput)
      3'b001:  outNext = resultNext;
      3'b010:  outNext = AccumulatorReadInput;
      3'b011:  outNext = DataReadInput;
      3'b100:  outNext = DATA_WIDTH'(pcNext);
      3'b101:  outNext = DATA_WIDTH'(flagNext);
      default: ;
    endcase
  end

  // Once halted every register freezes until reset.
  always_ff @(posedge clkInput or posedge resetInput) begin
    if (resetInput) begin
      AccumulatorWriteOutput   <= '0;
      DataWriteOutput          <= '0;
      OutputBinaryOutput       <= '0;
      ProgramCounterOutput     <= '0;
      ConditionFlagWriteOutput <= 1'b0;
      EndFlagWriteOutput       <= 1'b0;
    end else if (!EndFlagWriteOutput) begin
      AccumulatorWriteOutput   <= resultNext;
      DataWriteOutput          <= dataNext;
      OutputBinaryOutput       <= outNext;
      ProgramCounterOutput     <= pcNext;
      ConditionFlagWriteOutput <= flagNext;
      EndFlagWriteOutput       <= endNext;
    end
  end

endmodule

// File: tb/tb_harvard_alu.sv
// Directed bench for harvard_alu: each task drives one scenario and checks the
// registered outputs against hand-computed values.
module tb_harvard_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  op  = '0;
  logic [2:0]  sel = '0;
  logic [15:0] a   = '0;
  logic [15:0] d   = '0;
  logic        f   = 1'b0;
  logic [15:0] acc_o, data_o, out_o;
  logic [7:0]  pc_o;
  logic        flag_o, end_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  harvard_alu #(.DATA_WIDTH(16), .PC_WIDTH(8)) dut (
    .clkInput                 (clk),
    .resetInput               (rst),
    .OperandInput             (op),
    .OutputSelectorInput      (sel),
    .AccumulatorReadInput     (a),
    .DataReadInput            (d),
    .ConditionFlagReadInput   (f),
    .AccumulatorWriteOutput   (acc_o),
    .DataWriteOutput          (data_o),
    .OutputBinaryOutput       (out_o),
    .ProgramCounterOutput     (pc_o),
    .ConditionFlagWriteOutput (flag_o),
    .EndFlagWriteOutput       (end_o)
  );

  always #5 clk = ~clk;

  // Drive one instruction, let it clock in, sample 1 time unit after the edge.
  task automatic step(input logic [4:0] o, input logic [2:0] s, input logic [15:0] av,
                      input logic [15:0] dv, input logic fv);
    op = o; sel = s; a = av; d = dv; f = fv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk); @(posedge clk); #1;
    total_cnt++;
    if ({acc_o, data_o, out_o, pc_o, flag_o, end_o} !== 58'd0) $display("FAIL reset_init: got acc=%h data=%h out=%h pc=%h flag=%b end=%b, want all 0", acc_o, data_o, out_o, pc_o, flag_o, end_o);
    else pass_cnt++;
    rst = 1'b0;
    step(5'b00001, 3'b001, 16'h0000, 16'h1234, 1'b1);
    step(5'b00010, 3'b001, 16'h5555, 16'h0000, 1'b1);
    // Assert reset between edges: outputs must clear before the next edge.
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({acc_o, data_o, out_o, pc_o, flag_o, end_o} !== 58'd0) $display("FAIL reset_async: got acc=%h data=%h out=%h pc=%h flag=%b, want all 0", acc_o, data_o, out_o, pc_o, flag_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(5'b00000, 3'b000, 16'h0005, 16'h0000, 1'b0);
      total_cnt++;
      if (pc_o !== 8'(i) || acc_o !== 16'h0005) $display("FAIL nop_%0d: got pc=%h acc=%h, want pc=%h acc=0005", i, pc_o, acc_o, 8'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_add;
    for (int i = 0; i < 2; i++) begin
      step(5'b10000, 3'b001, 16'h000F, 16'h0001, 1'b0);
      total_cnt++;
      if (acc_o !== 16'h0010 || out_o !== 16'h0010 || flag_o !== 1'b0 || pc_o !== 8'(4 + i))
        $display("FAIL add_%0d: got acc=%h out=%h flag=%b pc=%h, want 0010 0010 0 %h", i, acc_o, out_o, flag_o, pc_o, 8'(4 + i));
      else pass_cnt++;
    end
  endtask

  task automatic test_arith;
    step(5'b10000, 3'b001, 16'hFFFF, 16'h0002, 1'b0);
    total_cnt++;
    if (acc_o !== 16'h0001 || flag_o !== 1'b1) $display("FAIL add_carry: got acc=%h flag=%b, want 0001 1", acc_o, flag_o);
    else pass_cnt++;
    step(5'b10001, 3'b001, 16'h0003, 16'h0005, 1'b0);
    total_cnt++;
    if (acc_o !== 16'hFFFE || flag_o !== 1'b1) $display("FAIL sub_borrow: got acc=%h flag=%b, want fffe 1", acc_o, flag_o);
    else pass_cnt++;
    step(5'b10001, 3'b001, 16'h0005, 16'h0003, 1'b1);
    total_cnt++;
    if (acc_o !== 16'h0002 || flag_o !== 1'b0) $display("FAIL sub_noborrow: got acc=%h flag=%b, want 0002 0", acc_o, flag_o);
    else pass_cnt++;
    step(5'b01011, 3'b001, 16'h1234, 16'h1234, 1'b0);
    total_cnt++;
    if (acc_o !== 16'h1234 || flag_o !== 1'b1) $display("FAIL cmpeq: got acc=%h flag=%b, want 1234 1", acc_o, flag_o);
    else pass_cnt++;
    step(5'b01100, 3'b001, 16'h0005, 16'h0003, 1'b1);
    total_cnt++;
    if (acc_o !== 16'h0005 || flag_o !== 1'b0) $display("FAIL cmplt: got acc=%h flag=%b, want 0005 0", acc_o, flag_o);
    else pass_cnt++;
    step(5'b00111, 3'b001, 16'h8001, 16'h0000, 1'b1);
    total_cnt++;
    if (acc_o !== 16'h0002 || flag_o !== 1'b1) $display("FAIL shl: got acc=%h flag=%b, want 0002 1", acc_o, flag_o);
    else pass_cnt++;
    step(5'b01000, 3'b001, 16'h8001, 16'h0000, 1'b0);
    total_cnt++;
    if (acc_o !== 16'h4000 || flag_o !== 1'b0) $display("FAIL shr: got acc=%h flag=%b, want 4000 0", acc_o, flag_o);
    else pass_cnt++;
    step(5'b00101, 3'b001, 16'hF0F0, 16'hFF00, 1'b0);
    total_cnt++;
    if (acc_o !== 16'h0FF0) $display("FAIL xor: got acc=%h, want 0ff0", acc_o);
    else pass_cnt++;
    step(5'b01010, 3'b001, 16'h0000, 16'h0000, 1'b0);
    total_cnt++;
    if (acc_o !== 16'hFFFF) $display("FAIL dec_wrap: got acc=%h, want ffff", acc_o);
    else pass_cnt++;
  endtask

  task automatic test_jumps;
    step(5'b10010, 3'b000, 16'h0000, 16'h01F0, 1'b0);
    total_cnt++;
    if (pc_o !== 8'hF0) $display("FAIL jmp: got pc=%h, want f0", pc_o);
    else pass_cnt++;
    step(5'b10011, 3'b000, 16'h0000, 16'h0010, 1'b0);
    total_cnt++;
    if (pc_o !== 8'hF1) $display("FAIL jf_not_taken: got pc=%h, want f1", pc_o);
    else pass_cnt++;
    step(5'b10011, 3'b000, 16'h0000, 16'h0010, 1'b1);
    total_cnt++;
    if (pc_o !== 8'h10) $display("FAIL jf_taken: got pc=%h, want 10", pc_o);
    else pass_cnt++;
    step(5'b10010, 3'b000, 16'h0000, 16'hABFF, 1'b0);
    step(5'b00000, 3'b000, 16'h0000, 16'h0000, 1'b0);
    total_cnt++;
    if (pc_o !== 8'h00) $display("FAIL pc_wrap: got pc=%h, want 00", pc_o);
    else pass_cnt++;
  endtask

  task automatic test_store_selector;
    step(5'b00010, 3'b001, 16'hBEEF, 16'h0000, 1'b0);
    total_cnt++;
    if (data_o !== 16'hBEEF || out_o !== 16'hBEEF) $display("FAIL store: got data=%h out=%h, want beef beef", data_o, out_o);
    else pass_cnt++;
    step(5'b00001, 3'b001, 16'h1111, 16'h0042, 1'b0);
    total_cnt++;
    if (data_o !== 16'hBEEF || acc_o !== 16'h0042 || out_o !== 16'h0042) $display("FAIL load: got data=%h acc=%h out=%h, want beef 0042 0042", data_o, acc_o, out_o);
    else pass_cnt++;
    step(5'b00000, 3'b000, 16'h0007, 16'h0009, 1'b0);
    total_cnt++;
    if (out_o !== 16'h0042) $display("FAIL sel_hold: got out=%h, want 0042", out_o);
    else pass_cnt++;
    step(5'b00000, 3'b011, 16'h0007, 16'h5A5A, 1'b0);
    total_cnt++;
    if (out_o !== 16'h5A5A) $display("FAIL sel_data: got out=%h, want 5a5a", out_o);
    else pass_cnt++;
    step(5'b00000, 3'b010, 16'h1357, 16'h0000, 1'b0);
    total_cnt++;
    if (out_o !== 16'h1357) $display("FAIL sel_acc: got out=%h, want 1357", out_o);
    else pass_cnt++;
    step(5'b10010, 3'b100, 16'h0000, 16'h0020, 1'b0);
    total_cnt++;
    if (out_o !== 16'h0020 || pc_o !== 8'h20) $display("FAIL sel_pc_jmp: got out=%h pc=%h, want 0020 20", out_o, pc_o);
    else pass_cnt++;
    step(5'b00000, 3'b100, 16'h0000, 16'h0000, 1'b0);
    total_cnt++;
    if (out_o !== 16'h0021) $display("FAIL sel_pc: got out=%h, want 0021", out_o);
    else pass_cnt++;
    step(5'b00000, 3'b101, 16'h0000, 16'h0000, 1'b1);
    total_cnt++;
    if (out_o !== 16'h0001) $display("FAIL sel_flag: got out=%h, want 0001", out_o);
    else pass_cnt++;
    step(5'b00000, 3'b110, 16'h0000, 16'h0000, 1'b0);
    total_cnt++;
    if (out_o !== 16'h0001) $display("FAIL sel_110_hold: got out=%h, want 0001", out_o);
    else pass_cnt++;
  endtask

  task automatic test_halt;
    step(5'b10010, 3'b000, 16'h0000, 16'h0040, 1'b0);
    step(5'b10100, 3'b001, 16'h0AAA, 16'h0000, 1'b0);
    total_cnt++;
    if (end_o !== 1'b1 || acc_o !== 16'h0AAA || out_o !== 16'h0AAA || pc_o !== 8'h41 || flag_o !== 1'b0)
      $display("FAIL halt: got end=%b acc=%h out=%h pc=%h flag=%b, want 1 0aaa 0aaa 41 0", end_o, acc_o, out_o, pc_o, flag_o);
    else pass_cnt++;
    step(5'b10000, 3'b001, 16'hFFFF, 16'h0001, 1'b1);
    step(5'b10010, 3'b100, 16'h0000, 16'h0099, 1'b1);
    step(5'b00010, 3'b011, 16'h7777, 16'h3333, 1'b1);
    total_cnt++;
    if ({acc_o, data_o, out_o, pc_o, flag_o, end_o} !== {16'h0AAA, 16'hBEEF, 16'h0AAA, 8'h41, 1'b0, 1'b1})
      $display("FAIL halt_freeze: got acc=%h data=%h out=%h pc=%h flag=%b end=%b, want 0aaa beef 0aaa 41 0 1", acc_o, data_o, out_o, pc_o, flag_o, end_o);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({acc_o, data_o, out_o, pc_o, flag_o, end_o} !== 58'd0) $display("FAIL halt_reset: got acc=%h data=%h out=%h pc=%h flag=%b end=%b, want all 0", acc_o, data_o, out_o, pc_o, flag_o, end_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    step(5'b01001, 3'b001, 16'h0003, 16'h0000, 1'b0);
    total_cnt++;
    if (acc_o !== 16'h0004 || pc_o !== 8'h01 || end_o !== 1'b0) $display("FAIL after_halt_inc: got acc=%h pc=%h end=%b, want 0004 01 0", acc_o, pc_o, end_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_jumps();
    test_store_selector();
    test_halt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/harvard_alu.md
Name: harvard_alu

Overview:
- Execute unit of the Harvard-architecture CPU: takes a 5-bit opcode, the current accumulator and a data-memory word, and produces registered results.
- Registered results: new accumulator value, data-memory write word, condition flag, end (halt) flag, 8-bit program counter and a selectable 16-bit display/output word.
- Sits between the instruction decoder, accumulator register and data memory; all outputs update on the rising clock edge.

Parameters:
- DATA_WIDTH, 16, width of accumulator, data and output buses
- PC_WIDTH, 8, width of program counter

Ports:
- clkInput  in  1  system clock, rising edge
- resetInput  in  1  asynchronous active-high reset
- OperandInput  in  5  opcode for this cycle
- OutputSelectorInput  in  3  source select for OutputBinaryOutput
- AccumulatorReadInput  in  16  current accumulator value
- DataReadInput  in  16  data-memory word / immediate operand
- ConditionFlagReadInput  in  1  current condition flag
- AccumulatorWriteOutput  out  16  next accumulator value
- DataWriteOutput  out  16  word to store to data memory
- OutputBinaryOutput  out  16  display/output word
- ProgramCounterOutput  out  8  program counter
- ConditionFlagWriteOutput  out  1  next condition flag
- EndFlagWriteOutput  out  1  halt indicator

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs are 0.
- Latency: every output is registered. Inputs sampled at edge N appear on outputs after edge N; there is no combinational input-to-output path.
- Notation: A = AccumulatorReadInput, D = DataReadInput, F = ConditionFlagReadInput, R = result.

Opcodes (unlisted codes behave as NOP):
- 00000 NOP: R = A
- 00001 LOAD: R = D
- 00010 STORE: R = A, DataWriteOutput <= A
- 00011 AND, 00100 OR, 00101 XOR: R = A op D
- 00110 NOT: R = ~A
- 00111 SHL: R = A << 1
- 01000 SHR (logical): R = A >> 1
- 01001 INC: R = A + 1
- 01010 DEC: R = A - 1
- 01011 CMPEQ: R = A, flag <= (A == D)
- 01100 CMPLT (unsigned): R = A, flag <= (A < D)
- 10000 ADD: R = A + D (mod 2^16), flag <= carry out of bit 15
- 10001 SUB: R = A - D (mod 2^16), flag <= borrow, i.e. 1 when A < D unsigned
- 10010 JMP: R = A, PC <= D[7:0]
- 10011 JF: R = A; if F = 1 then PC <= D[7:0], else PC increments
- 10100 HALT: R = A, EndFlagWriteOutput <= 1

Outputs each active cycle:
- AccumulatorWriteOutput <= R. Non-modifying ops pass A through unchanged.
- ConditionFlagWriteOutput <= F, except ADD, SUB, CMPEQ and CMPLT, which write the flag as defined above.
- DataWriteOutput holds its previous value, except on STORE.
- PC increments by 1 (255 wraps to 0), except on a taken jump.

Output selector (OutputBinaryOutput <= ):
- 000: hold previous value
- 001: R of this cycle
- 010: A
- 011: D
- 100: {8'b0, next PC value}
- 101: {15'b0, next flag value}
- 110, 111: hold

Halt:
- Once EndFlagWriteOutput = 1, all registers freeze (including PC and OutputBinaryOutput) and every opcode is ignored until reset.
- The HALT edge itself still updates OutputBinaryOutput and increments the PC.

Reset and corner cases:
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
- Arithmetic is unsigned, with wrap-around at 16 bits.
- SHL/SHR fill with 0 and do not modify the flag (flag passes F).
- Jump target uses only D[7:0]; upper bits of D are ignored.

Test Plan:
- Reset: assert resetInput between clock edges -> all outputs 0 at once; release, then NOP x3 with A=5 -> PC = 1, 2, 3 and AccumulatorWriteOutput = 5.
- ADD: Operand=10000, Selector=001, A=0x000F, D=0x0001, F=0 -> after each edge AccumulatorWriteOutput = 0x0010, OutputBinaryOutput = 0x0010, flag = 0, PC increments.
- Carry/borrow: ADD with A=0xFFFF, D=0x0002 -> 0x0001, flag = 1. SUB with A=3, D=5 -> 0xFFFE, flag = 1. CMPEQ with A=D=0x1234 -> flag = 1, accumulator = 0x1234.
- Jumps: JMP with D=0x01F0 -> PC = 0xF0. JF with F=0, D=0x10 -> PC = 0xF1. JF with F=1 -> PC = 0x10. Starting from PC = 255, a NOP wraps PC to 0.
- STORE and selector: STORE with A=0xBEEF -> DataWriteOutput = 0xBEEF; a following LOAD with D=0x0042 leaves DataWriteOutput = 0xBEEF and accumulator = 0x0042. Selector 000 holds the output; selectors 011 and 100 show D and PC respectively.
- HALT: Operand=10100 -> EndFlagWriteOutput = 1. Subsequent ADD/JMP leave every output unchanged. Asserting reset clears everything, including the end flag.
